// File: rtl/mips_mc_control.sv
// Main control FSM for the MIPS multi-cycle datapath: sequences fetch/decode/execute/memory/writeback.
// Optional macro MIPS_CTRL_EXC_EN routes illegal opcodes through an exception state (EXC).
module mips_mc_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             retire,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             illegal,
  output logic [3:0]       dbg_state
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXECUTE   = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDI_EX   = 4'd10,
    ADDI_WB   = 4'd11,
    EXC       = 4'd12
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  state_e           state_q, state_d;
  logic             retire_q, retire_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The branch decision is made in the datapath by gating pc_write_cond with zero.
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      retire_q  <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      retire_q  <= retire_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    retire_d  = 1'b0;
    illegal_d = illegal_q;
    case (state_q)
      FETCH:    if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_R:         state_d = EXECUTE;
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDI_EX;
          default: begin
`ifdef MIPS_CTRL_EXC_EN
            state_d = EXC;
`else
            state_d   = FETCH;
            illegal_d = 1'b1;
`endif
          end
        endcase
      end
      // The IR only loads in FETCH, so opcode is still the decoded instruction here.
      MEM_ADDR: state_d = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      MEM_READ: if (mem_ready) state_d = MEM_WB;
      MEM_WRITE: begin
        if (mem_ready) begin
          state_d  = FETCH;
          retire_d = 1'b1;
        end
      end
      EXECUTE:  state_d = R_WB;
      ADDI_EX:  state_d = ADDI_WB;
      MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB: begin
        state_d  = FETCH;
        retire_d = 1'b1;
      end
`ifdef MIPS_CTRL_EXC_EN
      EXC: begin
        state_d   = FETCH;
        illegal_d = 1'b1;
      end
`endif
      default:  state_d = FETCH;
    endcase
    cnt_d = retire_d ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    case (state_q)
      // PC and IR strobes fire only on the cycle the instruction fetch completes.
      FETCH: begin
        mem_read  = 1'b1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        alu_src_b = 2'b01;
      end
      DECODE:   alu_src_b = 2'b11;
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ADDI_WB:  reg_write = 1'b1;
`ifdef MIPS_CTRL_EXC_EN
      EXC: begin
        pc_write  = 1'b1;
        pc_source = 2'b11;
      end
`endif
      default: ;
    endcase
  end

  assign retire     = retire_q;
  assign retire_cnt = cnt_q;
  assign illegal    = illegal_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed-vector bench for mips_mc_control: per-cycle expected state and control word via a scoreboard queue.
module tb_mips_mc_control;

  localparam int CW = 3;
  localparam int W  = 4 + 16 + 1 + 1 + CW;

  localparam logic [3:0] S_F = 4'd0, S_D = 4'd1, S_MA = 4'd2, S_MR = 4'd3, S_MWB = 4'd4;
  localparam logic [3:0] S_MW = 4'd5, S_EX = 4'd6, S_RWB = 4'd7, S_BR = 4'd8, S_J = 4'd9;
  localparam logic [3:0] S_AEX = 4'd10, S_AWB = 4'd11, S_EXC = 4'd12;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD = 6'b111111;

  logic          clk, rst_n, zero, mem_ready;
  logic [5:0]    opcode;
  logic          pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic          mem_to_reg, reg_dst, reg_write, alu_src_a, retire, illegal;
  logic [1:0]    alu_src_b, alu_op, pc_source;
  logic [CW-1:0] retire_cnt;
  logic [3:0]    dbg_state;

  logic [W-1:0]  exp_q[$];
  int            id_q[$];
  int            tests_run = 0;
  int            tests_failed = 0;
  int            step_n = 0;
  event          obs_ev;

  mips_mc_control #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .retire(retire), .retire_cnt(retire_cnt),
    .illegal(illegal), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Control word: pw pwc iod mrd mwr irw m2r rdst rw asa asb aop ps
  function automatic logic [15:0] cw(input logic pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa,
                                     input logic [1:0] asb, aop, ps);
    return {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, ps};
  endfunction

  // Hand-written table of the control word each state must drive.
  function automatic logic [15:0] ctl_of(input logic [3:0] st, input logic mr);
    case (st)
      S_F:   return cw(mr, 0, 0, 1, 0, mr, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
      S_D:   return cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00);
      S_MA:  return cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00);
      S_MR:  return cw(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
      S_MWB: return cw(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00);
      S_MW:  return cw(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
      S_EX:  return cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00);
      S_RWB: return cw(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00);
      S_BR:  return cw(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01);
      S_J:   return cw(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10);
      S_AEX: return cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00);
      S_AWB: return cw(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00);
      S_EXC: return cw(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b11);
      default: return 16'h0000;
    endcase
  endfunction

  // Driver: apply inputs at the falling edge, queue the expected outputs for this cycle.
  task automatic step(input logic rst, input logic [5:0] op, input logic z, input logic mr,
                      input logic [3:0] st, input logic ret, input logic ill,
                      input logic [CW-1:0] cnt);
    rst_n = rst;
    opcode = op;
    zero = z;
    mem_ready = mr;
    #1;
    exp_q.push_back({st, ctl_of(st, mr), ret, ill, cnt});
    id_q.push_back(step_n);
    step_n++;
    -> obs_ev;
    @(negedge clk);
  endtask

  // Scoreboard monitor
  initial begin
    logic [W-1:0] exp_v, act_v;
    int id;
    forever begin
      @(obs_ev);
      act_v = {dbg_state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
               retire, illegal, retire_cnt};
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL step_underflow: got %h with no expected entry", act_v);
      end else begin
        exp_v = exp_q.pop_front();
        id = id_q.pop_front();
        if (act_v !== exp_v) begin
          tests_failed++;
          $display("FAIL step%0d: got %h (state %0d) expected %h (state %0d)",
                   id, act_v, act_v[W-1 -: 4], exp_v, exp_v[W-1 -: 4]);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    opcode = OP_R;
    zero = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    step(0, OP_R, 0, 1, S_F, 0, 0, 0);
    // R-type
    step(1, OP_R, 0, 1, S_F, 0, 0, 0);
    step(1, OP_R, 0, 1, S_D, 0, 0, 0);
    step(1, OP_R, 0, 1, S_EX, 0, 0, 0);
    step(1, OP_R, 0, 1, S_RWB, 0, 0, 0);
    // lw with two wait cycles in MEM_READ
    step(1, OP_LW, 0, 1, S_F, 1, 0, 1);
    step(1, OP_LW, 0, 1, S_D, 0, 0, 1);
    step(1, OP_LW, 0, 1, S_MA, 0, 0, 1);
    step(1, OP_LW, 0, 0, S_MR, 0, 0, 1);
    step(1, OP_LW, 0, 0, S_MR, 0, 0, 1);
    step(1, OP_LW, 0, 1, S_MR, 0, 0, 1);
    step(1, OP_LW, 0, 1, S_MWB, 0, 0, 1);
    // FETCH stall for three cycles, then sw
    step(1, OP_SW, 0, 0, S_F, 1, 0, 2);
    step(1, OP_SW, 0, 0, S_F, 0, 0, 2);
    step(1, OP_SW, 0, 0, S_F, 0, 0, 2);
    step(1, OP_SW, 0, 1, S_F, 0, 0, 2);
    step(1, OP_SW, 0, 1, S_D, 0, 0, 2);
    step(1, OP_SW, 0, 1, S_MA, 0, 0, 2);
    step(1, OP_SW, 0, 1, S_MW, 0, 0, 2);
    // beq with zero=1
    step(1, OP_BEQ, 1, 1, S_F, 1, 0, 3);
    step(1, OP_BEQ, 1, 1, S_D, 0, 0, 3);
    step(1, OP_BEQ, 1, 1, S_BR, 0, 0, 3);
    // j
    step(1, OP_J, 0, 1, S_F, 1, 0, 4);
    step(1, OP_J, 0, 1, S_D, 0, 0, 4);
    step(1, OP_J, 0, 1, S_J, 0, 0, 4);
    // addi
    step(1, OP_ADDI, 0, 1, S_F, 1, 0, 5);
    step(1, OP_ADDI, 0, 1, S_D, 0, 0, 5);
    step(1, OP_ADDI, 0, 1, S_AEX, 0, 0, 5);
    step(1, OP_ADDI, 0, 1, S_AWB, 0, 0, 5);
    // illegal opcode: no retire, sticky flag
    step(1, OP_BAD, 0, 1, S_F, 1, 0, 6);
    step(1, OP_BAD, 0, 1, S_D, 0, 0, 6);
`ifdef MIPS_CTRL_EXC_EN
    step(1, OP_BAD, 0, 1, S_EXC, 0, 0, 6);
`endif
    step(1, OP_J, 0, 1, S_F, 0, 1, 6);
    // two jumps: counter wraps from 7 to 0
    step(1, OP_J, 0, 1, S_D, 0, 1, 6);
    step(1, OP_J, 0, 1, S_J, 0, 1, 6);
    step(1, OP_J, 0, 1, S_F, 1, 1, 7);
    step(1, OP_J, 0, 1, S_D, 0, 1, 7);
    step(1, OP_J, 0, 1, S_J, 0, 1, 7);
    step(1, OP_SW, 0, 1, S_F, 1, 1, 0);
    // sw stalled in MEM_WRITE, then asynchronous reset
    step(1, OP_SW, 0, 1, S_D, 0, 1, 0);
    step(1, OP_SW, 0, 1, S_MA, 0, 1, 0);
    step(1, OP_SW, 0, 0, S_MW, 0, 1, 0);
    step(0, OP_SW, 0, 0, S_F, 0, 0, 0);
    // clean restart with an R-type
    step(1, OP_R, 0, 1, S_F, 0, 0, 0);
    step(1, OP_R, 0, 1, S_D, 0, 0, 0);
    step(1, OP_R, 0, 1, S_EX, 0, 0, 0);
    step(1, OP_R, 0, 1, S_RWB, 0, 0, 0);
    step(1, OP_R, 0, 0, S_F, 1, 0, 1);
    step(1, OP_R, 0, 0, S_F, 0, 0, 1);
    repeat (2) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL queue_drain: got %0d entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
